// File: rtl/uart_frame_parser.sv
// Byte-stream frame decoder: hunts for a sync word, decodes a LEN/CMD/ADDR header and
// streams payload bytes to a consumer through a first-word-fall-through FIFO.
module uart_frame_parser #(
  parameter logic [31:0] SYNC_WORD      = 32'hDEADBEEF,
  parameter int unsigned FIFO_AW        = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        hdr_valid,
  output logic [7:0]  hdr_cmd,
  output logic [15:0] hdr_len,
  output logic [31:0] hdr_addr,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  input  logic        pay_ready,
  output logic        pay_last,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] LEN_L   = 3'd1;
  localparam logic [2:0] LEN_H   = 3'd2;
  localparam logic [2:0] CMD     = 3'd3;
  localparam logic [2:0] ADDR    = 3'd4;
  localparam logic [2:0] PAYLOAD = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [1:0]  m_q, m_d;
  logic [1:0]  ab_q, ab_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] idle_q;
  logic [7:0]  sync_b;
  logic        hdr_load, fifo_wr, wr_last, tmo_hit, busy_d;

  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               full, push, pop;

  always_comb begin
    case (m_q)
      2'd0:    sync_b = SYNC_WORD[31:24];
      2'd1:    sync_b = SYNC_WORD[23:16];
      2'd2:    sync_b = SYNC_WORD[15:8];
      default: sync_b = SYNC_WORD[7:0];
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    ab_d     = ab_q;
    rem_d    = rem_q;
    len_d    = len_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    hdr_load = 1'b0;
    fifo_wr  = 1'b0;
    wr_last  = 1'b0;
    tmo_hit  = busy && !rx_ready && (idle_q == TIMEOUT_CYCLES - 24'd1);
    if (tmo_hit) begin
      state_d = HUNT;
      m_d     = 2'd0;
      ab_d    = 2'd0;
    end else if (rx_ready) begin
      case (state_q)
        HUNT: begin
          if (rx_data == sync_b) begin
            if (m_q == 2'd3) begin
              state_d = LEN_L;
              m_d     = 2'd0;
            end else begin
              m_d = m_q + 2'd1;
            end
          end else begin
            m_d = (rx_data == SYNC_WORD[31:24]) ? 2'd1 : 2'd0;
          end
        end
        LEN_L: begin
          len_d[7:0] = rx_data;
          state_d    = LEN_H;
        end
        LEN_H: begin
          len_d[15:8] = rx_data;
          state_d     = CMD;
        end
        CMD: begin
          cmd_d   = rx_data;
          ab_d    = 2'd0;
          state_d = ADDR;
        end
        ADDR: begin
          addr_d = {addr_q[15:0], rx_data};
          ab_d   = ab_q + 2'd1;
          if (ab_q == 2'd3) begin
            hdr_load = 1'b1;
            rem_d    = len_q;
            state_d  = (len_q == 16'd0) ? HUNT : PAYLOAD;
          end
        end
        PAYLOAD: begin
          fifo_wr = 1'b1;
          wr_last = (rem_q == 16'd1);
          if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
          if (rem_q <= 16'd1) state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
    busy_d = (state_d != HUNT) || (m_d != 2'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      m_q       <= 2'd0;
      ab_q      <= 2'd0;
      rem_q     <= 16'd0;
      len_q     <= 16'd0;
      cmd_q     <= 8'd0;
      addr_q    <= 24'd0;
      idle_q    <= 24'd0;
      busy      <= 1'b0;
      hdr_valid <= 1'b0;
      hdr_cmd   <= 8'd0;
      hdr_len   <= 16'd0;
      hdr_addr  <= 32'd0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      ab_q      <= ab_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      busy      <= busy_d;
      hdr_valid <= hdr_load;
      timeout   <= tmo_hit;
      if (hdr_load) begin
        hdr_len  <= len_q;
        hdr_cmd  <= cmd_q;
        hdr_addr <= {addr_q, rx_data};
      end
      if (rx_ready || !busy || tmo_hit) idle_q <= 24'd0;
      else                             idle_q <= idle_q + 24'd1;
      if (hdr_load)                 overrun <= 1'b0;
      else if (fifo_wr && !push)    overrun <= 1'b1;
    end
  end

  // Payload FIFO; a full FIFO still accepts a write when the head pops in the same cycle
  assign full      = (count_q == CW'(DEPTH));
  assign pay_valid = (count_q != CW'(0));
  assign pop       = pay_valid && pay_ready;
  assign push      = fifo_wr && (!full || pop);
  assign pay_data  = pay_valid ? mem[rd_ptr_q][7:0] : 8'd0;
  assign pay_last  = pay_valid && mem[rd_ptr_q][8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {wr_last, rx_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a payload scoreboard queue.
module tb_uart_frame_parser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        hdr_valid;
  logic [7:0]  hdr_cmd;
  logic [15:0] hdr_len;
  logic [31:0] hdr_addr;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_ready;
  logic        pay_last;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int hdr_cnt  = 0;
  int tmo_cnt  = 0;
  logic [9:0] exp_q[$];

  uart_frame_parser #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset_n(reset_n), .rx_ready(rx_ready), .rx_data(rx_data),
    .hdr_valid(hdr_valid), .hdr_cmd(hdr_cmd), .hdr_len(hdr_len), .hdr_addr(hdr_addr),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_last(pay_last),
    .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] len, input logic [31:0] addr);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(len[7:0]); send(len[15:8]); send(cmd);
    send(addr[31:24]); send(addr[23:16]); send(addr[15:8]); send(addr[7:0]);
  endtask

  task automatic check_hdr(input string tag, input logic [7:0] cmd, input logic [15:0] len,
                           input logic [31:0] addr);
    chk({tag, "_valid"}, 64'(hdr_valid), 64'(1));
    chk({tag, "_cmd"},   64'(hdr_cmd),   64'(cmd));
    chk({tag, "_len"},   64'(hdr_len),   64'(len));
    chk({tag, "_addr"},  64'(hdr_addr),  64'(addr));
  endtask

  task automatic pay(input logic [7:0] b, input logic last);
    exp_q.push_back({1'b0, last, b});
    send(b);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: count strobes, pop and compare each accepted payload byte
  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (reset_n) begin
      if (hdr_valid) hdr_cnt = hdr_cnt + 1;
      if (timeout)   tmo_cnt = tmo_cnt + 1;
      if (pay_valid && pay_ready) begin
        e = 10'h3FF;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("pay_byte", 64'({1'b0, pay_last, pay_data}), 64'(e));
      end
    end
  end

  initial begin : main
    int h0;
    int t0;
    reset_n   = 1'b0;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    pay_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_valid", 64'(hdr_valid), 64'(0));
    chk("rst_hdr_cmd",   64'(hdr_cmd),   64'(0));
    chk("rst_hdr_len",   64'(hdr_len),   64'(0));
    chk("rst_hdr_addr",  64'(hdr_addr),  64'(0));
    chk("rst_pay_valid", 64'(pay_valid), 64'(0));
    chk("rst_pay_last",  64'(pay_last),  64'(0));
    chk("rst_pay_data",  64'(pay_data),  64'(0));
    chk("rst_overrun",   64'(overrun),   64'(0));
    chk("rst_timeout",   64'(timeout),   64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal frame
    pay_ready = 1'b1;
    h0 = hdr_cnt;
    send_hdr(8'h01, 16'h0004, 32'h000000FF);
    check_hdr("nom_hdr", 8'h01, 16'h0004, 32'h000000FF);
    pay(8'h72, 1'b0); pay(8'h67, 1'b0); pay(8'h20, 1'b0); pay(8'h77, 1'b1);
    wait_drain("nom_drain");
    chk("nom_busy", 64'(busy), 64'(0));
    chk("nom_hdr_once", 64'(hdr_cnt - h0), 64'(1));

    // Sync recovery with zero-length payload
    send(8'h12); send(8'hDE);
    send_hdr(8'h05, 16'h0000, 32'h12345678);
    check_hdr("sync_hdr", 8'h05, 16'h0000, 32'h12345678);
    chk("sync_busy", 64'(busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("sync_no_pay", 64'(pay_valid), 64'(0));

    // Overrun: 20 bytes into a 16-deep FIFO with no consumer
    pay_ready = 1'b0;
    send_hdr(8'h02, 16'h0014, 32'h00001000);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back({2'b00, 8'(i)});
      send(8'(i));
    end
    chk("ovr_flag", 64'(overrun), 64'(1));
    chk("ovr_valid", 64'(pay_valid), 64'(1));
    pay_ready = 1'b1;
    wait_drain("ovr_drain");
    chk("ovr_sticky", 64'(overrun), 64'(1));
    send_hdr(8'h03, 16'h0000, 32'h00000000);
    chk("ovr_clear", 64'(overrun), 64'(0));

    // Timeout after a partial header
    t0 = tmo_cnt;
    chk("tmo_none_before", 64'(t0), 64'(0));
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h04);
    chk("tmo_busy_partial", 64'(busy), 64'(1));
    repeat (300) @(posedge clk);
    #1;
    chk("tmo_once", 64'(tmo_cnt - t0), 64'(1));
    chk("tmo_busy", 64'(busy), 64'(0));
    send_hdr(8'h06, 16'h0002, 32'hA5A5A5A5);
    check_hdr("tmo_hdr", 8'h06, 16'h0002, 32'hA5A5A5A5);
    pay(8'h11, 1'b0); pay(8'h22, 1'b1);
    wait_drain("tmo_drain");

    // Reset mid-payload
    pay_ready = 1'b0;
    send_hdr(8'h07, 16'h0004, 32'h00000055);
    send(8'hA1); send(8'hA2);
    reset_n = 1'b0;
    #1;
    chk("mrst_pay_valid", 64'(pay_valid), 64'(0));
    chk("mrst_busy",      64'(busy),      64'(0));
    chk("mrst_hdr_cmd",   64'(hdr_cmd),   64'(0));
    chk("mrst_hdr_len",   64'(hdr_len),   64'(0));
    chk("mrst_hdr_addr",  64'(hdr_addr),  64'(0));
    chk("mrst_pay_data",  64'(pay_data),  64'(0));
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    pay_ready = 1'b1;
    send_hdr(8'h08, 16'h0003, 32'hCAFE0000);
    check_hdr("mrst_hdr", 8'h08, 16'h0003, 32'hCAFE0000);
    pay(8'hB1, 1'b0); pay(8'hB2, 1'b0); pay(8'hB3, 1'b1);
    wait_drain("mrst_drain");

    // Backpressure: pay_ready toggles every cycle
    h0 = hdr_cnt;
    send_hdr(8'h09, 16'h0008, 32'hBEEF0000);
    check_hdr("bp_hdr", 8'h09, 16'h0008, 32'hBEEF0000);
    fork
      begin
        for (int i = 0; i < 8; i++) pay(8'hC0 + 8'(i), i == 7);
      end
      begin
        repeat (30) begin
          @(posedge clk);
          #1;
          pay_ready = ~pay_ready;
        end
      end
    join
    pay_ready = 1'b1;
    wait_drain("bp_drain");
    chk("bp_hdr_once", 64'(hdr_cnt - h0), 64'(1));
    chk("bp_busy", 64'(busy), 64'(0));

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
